// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Width helpers shared by the pipeline result collector files.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    // Width needed to index n items; never returns less than one bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return clog2w(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_result_collector_if.sv
// ============================================================================
// Module  : pipeline_result_collector_if
// Brief   : Issue credit, pipeline exit and result sink handshake bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_result_collector_if #(
    parameter int DW = 32
);
    logic          issue_valid;
    logic          issue_ready;
    logic          pipe_valid;
    logic [DW-1:0] pipe_data;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_ready;

    modport master (
        output issue_valid, pipe_valid, pipe_data, o_ready,
        input  issue_ready, o_valid, o_data
    );

    modport slave (
        input  issue_valid, pipe_valid, pipe_data, o_ready,
        output issue_ready, o_valid, o_data
    );
endinterface

`default_nettype wire

// File: rtl/prc_sa_fifo.sv
// ============================================================================
// Module  : prc_sa_fifo
// Brief   : Show-ahead synchronous FIFO, DW x DEPTH, any DEPTH >= 1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prc_sa_fifo
    import pipeline_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_w(DEPTH),
    localparam int PW    = clog2w(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_data,
    input  wire logic          i_pop,
    output logic      [CW-1:0] o_count,
    output logic      [DW-1:0] o_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Explicit wrap so non power-of-two depths stay in range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_result_collector.sv
// ============================================================================
// Module  : pipeline_result_collector
// Brief   : Credit-gated catch FIFO at the exit of a fixed-latency pipeline.
//           Optional PRC_BYPASS_EN: zero-cycle pipe->sink path when empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_result_collector
    import pipeline_pkg::*;
#(
    parameter  int LATENCY = 2,
    parameter  int DW      = 32,
    parameter  int DEPTH   = 4,
    localparam int CW      = cnt_w(DEPTH)
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    pipeline_result_collector_if.slave    bus,
    output logic [CW-1:0]                 occupancy,
    output logic                          err_unexp
);

    logic [CW-1:0] r_inflight;
    logic          r_err;
    logic [CW-1:0] w_count;
    logic [DW-1:0] w_fifo_data;
    logic [CW:0]   w_occ;
    logic          w_fire;
    logic          w_exit;
    logic          w_stored;
    logic          w_push;
    logic          w_pop;

    // Below LATENCY+1 entries the credit loop limits issue rate; still correct.
    if (DEPTH < LATENCY + 1) begin : g_reduced_rate
    end

    assign w_occ           = {1'b0, r_inflight} + {1'b0, w_count};
    assign bus.issue_ready = w_occ < (CW+1)'(DEPTH);
    assign occupancy       = w_occ[CW-1:0];
    assign err_unexp       = r_err;
    assign w_fire          = bus.issue_valid && bus.issue_ready;
    assign w_exit          = bus.pipe_valid && (r_inflight != '0);
    assign w_stored        = (w_count != '0);
    assign w_pop           = w_stored && bus.o_ready;

`ifdef PRC_BYPASS_EN
    logic w_byp;
    assign w_byp       = !w_stored && w_exit && bus.o_ready;
    assign w_push      = w_exit && !w_byp;
    assign bus.o_valid = w_stored || w_byp;
    assign bus.o_data  = w_byp ? bus.pipe_data : w_fifo_data;
`else
    assign w_push      = w_exit;
    assign bus.o_valid = w_stored;
    assign bus.o_data  = w_fifo_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_fire && !w_exit) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_fire && w_exit) begin
                r_inflight <= r_inflight - CW'(1);
            end
            if (bus.pipe_valid && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    prc_sa_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (bus.pipe_data),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_data  (w_fifo_data)
    );

endmodule

`default_nettype wire
